axis_fmcw_rti_avg: RTL and testbench
====================================

Name: axis_fmcw_rti_avg

Overview:
- AXI4-Stream post-processor placed after the FFT core in the FMCW radar chain.
- Averages complex FFT bins over 2^A consecutive frames; alternating upbeat/downbeat chirp frames are averaged together. Emits range-time-intensity (RTI) averages on m_axis_avg.
- Also emits an STFT history stream: each bin, the same bin from the last STFT_CHANNELS frames side by side.

Parameters:
- AXIS_TDATA_WIDTH, 24, complex sample width {im, re}; each half is a signed two's-complement value.
- AXIS_TUSER_WIDTH, 16, FFT index sideband width.
- STFT_CHANNELS, 3, number of frames packed on m_axis_stft.
- MAX_NFFT_LOG2, 12, memory address width; max FFT length 4096.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- cfg_data  in  20  [3:0]=N (log2 FFT length), [7:4]=A (log2 frames averaged, 0..15), [19:8]=B (bins kept).
- s_axis_fft_tdata  in  AXIS_TDATA_WIDTH  {im, re}.
- s_axis_fft_tuser  in  AXIS_TUSER_WIDTH  bin index, natural value in bits [N-1:0]; samples arrive in any order (bit-reversed in practice).
- s_axis_fft_tlast  in  1  last sample of frame.
- s_axis_fft_tvalid  in  1.
- s_axis_fft_tready  out  1.
- m_axis_avg_tdata  out  AXIS_TDATA_WIDTH  averaged {im, re}.
- m_axis_avg_tuser  out  AXIS_TUSER_WIDTH  bin index, zero-extended.
- m_axis_avg_tlast, m_axis_avg_tvalid  out  1.
- m_axis_avg_tready  in  1.
- m_axis_stft_tdata  out  AXIS_TDATA_WIDTH*STFT_CHANNELS  channel k at bits [24k+23:24k] = frame n-k.
- m_axis_stft_tlast, m_axis_stft_tvalid  out  1.
- m_axis_stft_tready  in  1.

Behaviour:
- Reset: all tvalid=0, all tlast=0, all output tdata/tuser=0, frame counter=0, history-fill counter=0. Accumulator and history RAMs are not cleared.
- Handshake:
  - s_axis_fft_tready = (!m_avg_tvalid | m_avg_tready) & (!m_stft_tvalid | m_stft_tready).
  - A sample is accepted when s_tvalid & s_tready.
  - Each output has one register stage; tvalid holds until its tready.
- Latency: accepted sample to output tvalid = 1 cycle. Full throughput of one sample per cycle when both readies are high.
- cfg_data is latched at the first accepted sample of each frame (after reset or after a tlast) and held for the whole frame.
- Bin b = tuser[N-1:0]. A sample is "kept" if b < B, or if it carries tlast.
- Frame counter f counts 0..2^A-1, increments on an accepted tlast, and wraps to 0.
- Accumulators: re and im are accumulated separately, signed, 27 bits each, in a RAM of 2^MAX_NFFT_LOG2 entries addressed by b.
  - f==0: acc[b] = sample.
  - Otherwise: acc[b] = acc[b] + sample. Read-modify-write completes in the accept cycle.
- Average output: only when f==2^A-1 and the sample is kept.
  - m_avg tdata = (acc[b] + sample) >>> A per component, truncated to 12 bits.
  - m_avg tuser = b; m_avg tlast = s_tlast.
  - A=0: every kept sample passes through unchanged.
- STFT output: every kept sample in every frame.
  - Channel 0 = current sample; channel k = bin b from frame n-k.
  - A channel k that has not yet been filled since reset (fill counter < k) outputs 0.
  - m_stft tlast = s_tlast.
  - History RAMs (STFT_CHANNELS-1 of them) shift on accept.
- Dropped samples (not kept) still update the accumulators and history but produce no output beat.
- B=0 with no tlast: no output beats. B > 2^N: all bins are kept.

Optional Feature:
- FMCW_RTI_ROUND_EN defined: before the shift, add 2^(A-1) when A>0, giving round-half-up.
- Undefined: the average is an arithmetic-shift truncation (floor).

Decomposition:
- Package fmcw_rti_pkg holds:
  - cfg field offsets and widths.
  - Accumulator width constant (27).
  - A complex-sample typedef {im, re}.
- One sub-module, fmcw_rti_ram: simple dual-port RAM (combinational read, synchronous write), parameterised by width and depth. It is instantiated for the accumulators and for each history channel.

Test Plan:
- Reset then cfg {600,2,10}; re=im incrementing by 2 per sample; tuser = bit-reverse(addr); tready=1.
  - Frames 0-2: no avg beats.
  - Frame 3: one avg beat per bin <600, each equal to the 4-frame mean; tlast beat at addr 1023.
- Constant input 100+j(-100), cfg A=3 → every avg beat = 100, -100. With the macro, 7+j0 input gives 7.
- stft check: frame 0 channels 1 and 2 = 0; frame 2 channel 2 = frame-0 value at the same bin.
- Backpressure: m_avg_tready toggled 50% → s_tready follows the rule; no beat lost or duplicated; data stable while stalled.
- cfg A=0, B=4 → avg and stft each emit bins 0-3 unchanged plus the tlast beat.
- Assert areset mid-frame → all tvalid=0 next cycle; the following frame is treated as f=0 and stft channels >0 output 0.

Source files
------------

// File: rtl/fmcw_rti_pkg.sv
// Shared definitions for the FMCW RTI averager: configuration word layout,
// accumulator width, complex sample types and small decode helpers.
package fmcw_rti_pkg;

   // Configuration word: [3:0] N = log2 FFT length, [7:4] A = log2 frames
   // averaged, [19:8] B = number of bins kept.
   localparam int CFG_W     = 20;
   localparam int CFG_N_LSB = 0;
   localparam int CFG_N_W   = 4;
   localparam int CFG_A_LSB = 4;
   localparam int CFG_A_W   = 4;
   localparam int CFG_B_LSB = 8;
   localparam int CFG_B_W   = 12;

   // One component of a complex FFT sample, and the per-component
   // accumulator width (enough for 2^15 frames of 12-bit values).
   localparam int COMP_W = 12;
   localparam int ACC_W  = 27;

   typedef struct packed {
      logic [CFG_B_W-1:0] b;
      logic [CFG_A_W-1:0] a;
      logic [CFG_N_W-1:0] n;
   } cfg_t;

   typedef struct packed {
      logic signed [COMP_W-1:0] im;
      logic signed [COMP_W-1:0] re;
   } cplx_t;

   typedef struct packed {
      logic signed [ACC_W-1:0] im;
      logic signed [ACC_W-1:0] re;
   } acc_t;

   function automatic cfg_t decode_cfg(input logic [CFG_W-1:0] raw);
      cfg_t c;
      c.n = raw[CFG_N_LSB +: CFG_N_W];
      c.a = raw[CFG_A_LSB +: CFG_A_W];
      c.b = raw[CFG_B_LSB +: CFG_B_W];
      return c;
   endfunction

   function automatic logic signed [ACC_W-1:0] sext_comp(input logic signed [COMP_W-1:0] v);
      return {{(ACC_W-COMP_W){v[COMP_W-1]}}, v};
   endfunction

endpackage

// File: rtl/fmcw_rti_ram.sv
// Simple dual-port RAM: combinational read, synchronous write. A read of the
// address being written in the same cycle returns the old contents.
module fmcw_rti_ram #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [2**ADDR_W];

   // Write port.
   // NOTE: the array has no reset branch; clearing thousands of words is not
   // possible in one cycle and the contents are overwritten before use.
   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/axis_fmcw_rti_avg.sv
// FMCW range-time-intensity averager. Accumulates complex FFT bins over 2^A
// frames and emits the average on the last frame (m_axis_avg), and emits each
// kept bin alongside the same bin from the previous STFT_CHANNELS-1 frames
// (m_axis_stft).
// Build option: define FMCW_RTI_ROUND_EN to round the average half-up instead
// of truncating toward minus infinity.
module axis_fmcw_rti_avg
   import fmcw_rti_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH = 24,
   parameter int AXIS_TUSER_WIDTH = 16,
   parameter int STFT_CHANNELS    = 3,
   parameter int MAX_NFFT_LOG2    = 12
) (
   input  logic                                      aclk,
   input  logic                                      areset,
   input  logic [CFG_W-1:0]                          cfg_data,
   input  logic [AXIS_TDATA_WIDTH-1:0]               s_axis_fft_tdata,
   input  logic [AXIS_TUSER_WIDTH-1:0]               s_axis_fft_tuser,
   input  logic                                      s_axis_fft_tlast,
   input  logic                                      s_axis_fft_tvalid,
   output logic                                      s_axis_fft_tready,
   output logic [AXIS_TDATA_WIDTH-1:0]               m_axis_avg_tdata,
   output logic [AXIS_TUSER_WIDTH-1:0]               m_axis_avg_tuser,
   output logic                                      m_axis_avg_tlast,
   output logic                                      m_axis_avg_tvalid,
   input  logic                                      m_axis_avg_tready,
   output logic [AXIS_TDATA_WIDTH*STFT_CHANNELS-1:0] m_axis_stft_tdata,
   output logic                                      m_axis_stft_tlast,
   output logic                                      m_axis_stft_tvalid,
   input  logic                                      m_axis_stft_tready
);

   // Frame counter must reach 2^15-1 for A=15.
   localparam int FC_W   = 15;
   localparam int FILL_W = $clog2(STFT_CHANNELS) + 1;
   localparam int CH_W   = AXIS_TDATA_WIDTH;

   cfg_t                                    cfg_q, cfg_cur;
   logic                                    mid_frame;
   logic [FC_W-1:0]                         frame_cnt, frame_max;
   logic [FILL_W-1:0]                       fill_cnt;
   logic                                    accept, keep, last_frame, emit_avg;
   logic [AXIS_TUSER_WIDTH-1:0]             bin;
   logic [MAX_NFFT_LOG2-1:0]                addr;
   cplx_t                                   sample, avg;
   acc_t                                    acc_rd, acc_wr;
   logic [2*ACC_W-1:0]                      acc_rdata;
   logic signed [ACC_W-1:0]                 rnd, sum_re, sum_im;
   logic [STFT_CHANNELS-1:0][CH_W-1:0]      chan;
   logic [STFT_CHANNELS*CH_W-1:0]           stft_word;

   // Input is accepted only when both output registers can take a beat.
   assign s_axis_fft_tready = (!m_axis_avg_tvalid  || m_axis_avg_tready) &&
                              (!m_axis_stft_tvalid || m_axis_stft_tready);
   assign accept = s_axis_fft_tvalid && s_axis_fft_tready;

   // The first beat of a frame uses the live cfg word; later beats the copy.
   assign cfg_cur = mid_frame ? cfg_q : decode_cfg(cfg_data);
   assign sample  = s_axis_fft_tdata;

   assign bin  = s_axis_fft_tuser &
                 ((AXIS_TUSER_WIDTH'(1) << cfg_cur.n) - AXIS_TUSER_WIDTH'(1));
   assign addr = bin[MAX_NFFT_LOG2-1:0];
   assign keep = (bin < AXIS_TUSER_WIDTH'(cfg_cur.b)) || s_axis_fft_tlast;

   assign frame_max  = (FC_W'(1) << cfg_cur.a) - FC_W'(1);
   assign last_frame = (frame_cnt >= frame_max);
   assign emit_avg   = keep && last_frame;

   fmcw_rti_ram #(
      .WIDTH  (2*ACC_W),
      .ADDR_W (MAX_NFFT_LOG2)
   ) u_acc_ram (
      .clk   (aclk),
      .we    (accept),
      .waddr (addr),
      .wdata (acc_wr),
      .raddr (addr),
      .rdata (acc_rdata)
   );

   assign acc_rd = acc_rdata;

   // Accumulate the sample into its bin and form the scaled average.
   always_comb begin
      // NOTE: every variable driven here gets a value first so no path can
      // leave it holding its previous value (which would infer a latch).
      acc_wr.re = sext_comp(sample.re);
      acc_wr.im = sext_comp(sample.im);
      rnd       = '0;
      if (frame_cnt != '0) begin
         acc_wr.re = acc_rd.re + sext_comp(sample.re);
         acc_wr.im = acc_rd.im + sext_comp(sample.im);
      end
`ifdef FMCW_RTI_ROUND_EN
      if (cfg_cur.a != '0) begin
         rnd = ACC_W'(1) << (cfg_cur.a - CFG_A_W'(1));
      end
`endif
      sum_re = (acc_wr.re + rnd) >>> cfg_cur.a;
      sum_im = (acc_wr.im + rnd) >>> cfg_cur.a;
      avg.re = sum_re[COMP_W-1:0];
      avg.im = sum_im[COMP_W-1:0];
   end

   // History chain: channel 0 is the live sample, channel k holds bin b as it
   // was k frames ago; every accepted beat pushes one step down the chain.
   assign chan[0] = s_axis_fft_tdata;

   for (genvar k = 1; k < STFT_CHANNELS; k++) begin : g_hist
      fmcw_rti_ram #(
         .WIDTH  (CH_W),
         .ADDR_W (MAX_NFFT_LOG2)
      ) u_hist_ram (
         .clk   (aclk),
         .we    (accept),
         .waddr (addr),
         .wdata (chan[k-1]),
         .raddr (addr),
         .rdata (chan[k])
      );
   end

   // Blank history channels that have not seen a full frame since reset.
   always_comb begin
      stft_word = '0;
      for (int k = 0; k < STFT_CHANNELS; k++) begin
         if (k == 0 || fill_cnt >= FILL_W'(k)) begin
            stft_word[k*CH_W +: CH_W] = chan[k];
         end
      end
   end

   // Frame bookkeeping: cfg capture, frame counter and history fill level.
   always_ff @(posedge aclk) begin
      if (areset) begin
         mid_frame <= 1'b0;
         cfg_q     <= '0;
         frame_cnt <= '0;
         fill_cnt  <= '0;
      end else if (accept) begin
         cfg_q     <= cfg_cur;
         mid_frame <= !s_axis_fft_tlast;
         if (s_axis_fft_tlast) begin
            frame_cnt <= last_frame ? '0 : frame_cnt + FC_W'(1);
            if (fill_cnt < FILL_W'(STFT_CHANNELS-1)) begin
               fill_cnt <= fill_cnt + FILL_W'(1);
            end
         end
      end
   end

   // Average output register: loads on accept, drains on tready.
   always_ff @(posedge aclk) begin
      if (areset) begin
         m_axis_avg_tvalid <= 1'b0;
         m_axis_avg_tlast  <= 1'b0;
         m_axis_avg_tdata  <= '0;
         m_axis_avg_tuser  <= '0;
      end else if (accept) begin
         m_axis_avg_tvalid <= emit_avg;
         if (emit_avg) begin
            m_axis_avg_tdata <= avg;
            m_axis_avg_tuser <= bin;
            m_axis_avg_tlast <= s_axis_fft_tlast;
         end
      end else if (m_axis_avg_tready) begin
         m_axis_avg_tvalid <= 1'b0;
      end
   end

   // STFT output register: loads every kept beat, drains on tready.
   always_ff @(posedge aclk) begin
      if (areset) begin
         m_axis_stft_tvalid <= 1'b0;
         m_axis_stft_tlast  <= 1'b0;
         m_axis_stft_tdata  <= '0;
      end else if (accept) begin
         m_axis_stft_tvalid <= keep;
         if (keep) begin
            m_axis_stft_tdata <= stft_word;
            m_axis_stft_tlast <= s_axis_fft_tlast;
         end
      end else if (m_axis_stft_tready) begin
         m_axis_stft_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_fmcw_rti_avg.sv
// Scoreboard bench for axis_fmcw_rti_avg: a frame-level reference model
// pushes expected beats into queues; a monitor pops and compares them as the
// DUT hands beats over, and watches the handshake rules every cycle.
module tb_axis_fmcw_rti_avg;

   localparam int DW = 24;
   localparam int UW = 16;
   localparam int CH = 3;
   localparam int AW = 12;

   logic            aclk = 1'b0;
   logic            areset;
   logic [19:0]     cfg_data;
   logic [DW-1:0]   s_tdata;
   logic [UW-1:0]   s_tuser;
   logic            s_tlast, s_tvalid, s_tready;
   logic [DW-1:0]   avg_tdata;
   logic [UW-1:0]   avg_tuser;
   logic            avg_tlast, avg_tvalid, avg_tready;
   logic [DW*CH-1:0] stft_tdata;
   logic            stft_tlast, stft_tvalid, stft_tready;

   always #5 aclk = ~aclk;

   axis_fmcw_rti_avg #(
      .AXIS_TDATA_WIDTH (DW),
      .AXIS_TUSER_WIDTH (UW),
      .STFT_CHANNELS    (CH),
      .MAX_NFFT_LOG2    (AW)
   ) dut (
      .aclk               (aclk),
      .areset             (areset),
      .cfg_data           (cfg_data),
      .s_axis_fft_tdata   (s_tdata),
      .s_axis_fft_tuser   (s_tuser),
      .s_axis_fft_tlast   (s_tlast),
      .s_axis_fft_tvalid  (s_tvalid),
      .s_axis_fft_tready  (s_tready),
      .m_axis_avg_tdata   (avg_tdata),
      .m_axis_avg_tuser   (avg_tuser),
      .m_axis_avg_tlast   (avg_tlast),
      .m_axis_avg_tvalid  (avg_tvalid),
      .m_axis_avg_tready  (avg_tready),
      .m_axis_stft_tdata  (stft_tdata),
      .m_axis_stft_tlast  (stft_tlast),
      .m_axis_stft_tvalid (stft_tvalid),
      .m_axis_stft_tready (stft_tready)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic [UW-1:0] user;
      logic          last;
   } avg_exp_t;

   typedef struct {
      logic [DW*CH-1:0] data;
      logic             last;
   } stft_exp_t;

   avg_exp_t  avg_q[$];
   stft_exp_t stft_q[$];

   int checks   = 0;
   int failures = 0;
   int avg_seen = 0;
   int stft_seen = 0;
   int rdy_mode = 0;   // 0: both ready, 1: random, 2: both stalled
   int inc_val  = 0;

   // Reference model state: per-bin running sums, frame position inside the
   // averaging window, frames since reset, and the raw bins of recent frames.
   int          m_sum_re [4096];
   int          m_sum_im [4096];
   int          m_frame  = 0;
   int          m_nframes = 0;
   logic [23:0] m_frm [CH][4096];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int s12(input int v);
      logic signed [11:0] t;
      t = v[11:0];
      return int'(t);
   endfunction

   function automatic int bitrev(input int v, input int n);
      int r = 0;
      for (int i = 0; i < n; i++) begin
         if (v[i]) r = r | (1 << (n - 1 - i));
      end
      return r;
   endfunction

   // Model one accepted sample of a frame configured with (a, bk).
   task automatic model_sample(input int re, input int im, input int bin,
                               input logic last, input int a, input int bk);
      avg_exp_t    ea;
      stft_exp_t   es;
      int          vr, vi;
      logic [23:0] cur, ch;
      logic        kept;
      kept = (bin < bk) || last;
      cur  = {im[11:0], re[11:0]};
      if (m_frame == 0) begin
         m_sum_re[bin] = re;
         m_sum_im[bin] = im;
      end else begin
         m_sum_re[bin] = m_sum_re[bin] + re;
         m_sum_im[bin] = m_sum_im[bin] + im;
      end
      if (kept && m_frame == (1 << a) - 1) begin
         vr = m_sum_re[bin];
         vi = m_sum_im[bin];
`ifdef FMCW_RTI_ROUND_EN
         if (a > 0) begin
            vr = vr + (1 << (a - 1));
            vi = vi + (1 << (a - 1));
         end
`endif
         vr = vr >>> a;
         vi = vi >>> a;
         ea.data = {vi[11:0], vr[11:0]};
         ea.user = UW'(bin);
         ea.last = last;
         avg_q.push_back(ea);
      end
      if (kept) begin
         es.data = '0;
         for (int k = 0; k < CH; k++) begin
            if (k == 0)              ch = cur;
            else if (m_nframes >= k) ch = m_frm[(m_nframes - k) % CH][bin];
            else                     ch = '0;
            es.data[24*k +: 24] = ch;
         end
         es.last = last;
         stft_q.push_back(es);
      end
      m_frm[m_nframes % CH][bin] = cur;
      if (last) begin
         m_nframes++;
         m_frame = (m_frame == (1 << a) - 1) ? 0 : m_frame + 1;
      end
   endtask

   // Present one beat, hold it until accepted, then update the model.
   task automatic send_beat(input int re, input int im, input logic [UW-1:0] user,
                            input logic last, input bit gaps, input int bin,
                            input int a, input int bk);
      bit acc;
      int budget;
      if (gaps && $urandom_range(0, 3) == 0) begin
         @(posedge aclk);
         #1;
      end
      s_tdata  = {im[11:0], re[11:0]};
      s_tuser  = user;
      s_tlast  = last;
      s_tvalid = 1'b1;
      acc      = 1'b0;
      budget   = 0;
      while (!acc) begin
         @(negedge aclk);
         acc = s_tready;
         @(posedge aclk);
         #1;
         budget++;
         if (!acc && budget > 1000) begin
            failures++;
            $display("FAIL s_tready_timeout actual=stalled required=accept within 1000 cycles");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "input stalled");
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      model_sample(re, im, bin, last, a, bk);
   endtask

   // Send nsend beats of a frame of 2^n bins. mode 0: re=im incrementing by
   // 2; mode 1: constant (cre, cim); mode 2: random. cfg_data is scrambled
   // after the first beat, which the DUT must ignore until the next frame.
   task automatic send_frame(input int n, input int a, input int bk, input int mode,
                             input bit rev, input bit gaps, input int nsend,
                             input int cre, input int cim);
      int len, idx, re, im;
      logic [UW-1:0] user;
      len = 1 << n;
      cfg_data = {bk[11:0], a[3:0], n[3:0]};
      for (int i = 0; i < nsend; i++) begin
         idx = rev ? bitrev(i, n) : i;
         case (mode)
            0: begin
               re = s12(inc_val);
               im = re;
               inc_val += 2;
            end
            1: begin
               re = cre;
               im = cim;
            end
            default: begin
               re = s12(int'($urandom_range(0, 4095)));
               im = s12(int'($urandom_range(0, 4095)));
            end
         endcase
         user = (UW'($urandom) << n) | UW'(idx);
         send_beat(re, im, user, i == len - 1, gaps, idx, a, bk);
         cfg_data = 20'($urandom);
      end
   endtask

   task automatic drain(input string tag);
      rdy_mode = 0;
      for (int i = 0; i < 500 && (avg_q.size() != 0 || stft_q.size() != 0); i++) begin
         @(posedge aclk);
      end
      repeat (2) @(posedge aclk);
      #1;
      check({tag, "_queues_empty"}, {avg_q.size(), stft_q.size()}, '0);
   endtask

   task automatic reset_model();
      avg_q.delete();
      stft_q.delete();
      m_frame   = 0;
      m_nframes = 0;
   endtask

   // Ready generator.
   initial begin
      forever begin
         @(posedge aclk);
         #1;
         case (rdy_mode)
            0: begin
               avg_tready  = 1'b1;
               stft_tready = 1'b1;
            end
            1: begin
               avg_tready  = 1'($urandom);
               stft_tready = 1'($urandom);
            end
            default: begin
               avg_tready  = 1'b0;
               stft_tready = 1'b0;
            end
         endcase
      end
   end

   // Monitor: handshake rule, stall stability, scoreboard comparison.
   initial begin
      logic            pa_stall = 1'b0;
      logic            ps_stall = 1'b0;
      logic [40:0]     pa;
      logic [72:0]     ps;
      avg_exp_t        ea;
      stft_exp_t       es;
      forever begin
         @(negedge aclk);
         if (areset) begin
            pa_stall = 1'b0;
            ps_stall = 1'b0;
         end else begin
            check("s_tready_rule", s_tready,
                  (!avg_tvalid || avg_tready) && (!stft_tvalid || stft_tready));
            if (pa_stall) check("avg_stall_hold", {avg_tvalid, avg_tdata, avg_tuser, avg_tlast}, {1'b1, pa});
            if (ps_stall) check("stft_stall_hold", {stft_tvalid, stft_tdata, stft_tlast}, {1'b1, ps});
            if (avg_tvalid && avg_tready) begin
               avg_seen++;
               if (avg_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL avg_unexpected_beat actual=%0h/%0h required=no beat t=%0t",
                           avg_tdata, avg_tuser, $time);
               end else begin
                  ea = avg_q.pop_front();
                  check("avg_beat", {avg_tdata, avg_tuser, avg_tlast}, {ea.data, ea.user, ea.last});
               end
            end
            if (stft_tvalid && stft_tready) begin
               stft_seen++;
               if (stft_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL stft_unexpected_beat actual=%0h required=no beat t=%0t",
                           stft_tdata, $time);
               end else begin
                  es = stft_q.pop_front();
                  check("stft_beat", {stft_tdata, stft_tlast}, {es.data, es.last});
               end
            end
            pa_stall = avg_tvalid && !avg_tready;
            pa       = {avg_tdata, avg_tuser, avg_tlast};
            ps_stall = stft_tvalid && !stft_tready;
            ps       = {stft_tdata, stft_tlast};
         end
      end
   end

   // Main sequence.
   initial begin
      int a0, s0;
      areset      = 1'b1;
      cfg_data    = '0;
      s_tdata     = '0;
      s_tuser     = '0;
      s_tlast     = 1'b0;
      s_tvalid    = 1'b0;
      avg_tready  = 1'b1;
      stft_tready = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      check("reset_valids", {avg_tvalid, stft_tvalid}, 2'b00);
      check("reset_lasts", {avg_tlast, stft_tlast}, 2'b00);
      check("reset_avg_data", {avg_tdata, avg_tuser}, '0);
      check("reset_stft_data", stft_tdata, '0);
      check("reset_s_tready", s_tready, 1'b1);
      areset = 1'b0;

      // 4-frame RTI average, N=10, A=2, B=600, bit-reversed order.
      for (int f = 0; f < 3; f++) send_frame(10, 2, 600, 0, 1'b1, 1'b0, 1024, 0, 0);
      drain("rti_frames0to2");
      check("avg_beats_frames0to2", avg_seen, 0);
      send_frame(10, 2, 600, 0, 1'b1, 1'b0, 1024, 0, 0);
      drain("rti_frame3");
      check("avg_beats_frame3", avg_seen, 601);

      // Constant input over 8 frames, then random data with backpressure.
      areset = 1'b1;
      @(posedge aclk);
      #1;
      areset = 1'b0;
      reset_model();
      for (int f = 0; f < 8; f++) send_frame(5, 3, 32, 1, 1'b1, 1'b1, 32, 100, -100);
      drain("const_avg");
      rdy_mode = 1;
      for (int f = 0; f < 8; f++) send_frame(4, 3, 16, 2, 1'b1, 1'b1, 16, 0, 0);
      for (int f = 0; f < 4; f++) send_frame(6, 1, 40, 2, 1'b1, 1'b1, 64, 0, 0);
      drain("backpressure");

      // A=0 pass-through with B=4, then B=0 and B beyond 2^N.
      areset = 1'b1;
      @(posedge aclk);
      #1;
      areset = 1'b0;
      reset_model();
      a0 = avg_seen;
      s0 = stft_seen;
      for (int f = 0; f < 3; f++) send_frame(3, 0, 4, 2, 1'b0, 1'b1, 8, 0, 0);
      drain("a0_b4");
      check("a0_b4_avg_count", avg_seen - a0, 15);
      check("a0_b4_stft_count", stft_seen - s0, 15);
      a0 = avg_seen;
      s0 = stft_seen;
      send_frame(3, 0, 0, 2, 1'b0, 1'b1, 8, 0, 0);
      drain("b0");
      check("b0_avg_count", avg_seen - a0, 1);
      check("b0_stft_count", stft_seen - s0, 1);
      for (int f = 0; f < 2; f++) send_frame(3, 1, 100, 2, 1'b1, 1'b1, 8, 0, 0);
      drain("b_large");

      // Reset in the middle of a frame with outputs stalled.
      send_frame(4, 1, 16, 2, 1'b0, 1'b0, 7, 0, 0);
      rdy_mode    = 2;
      avg_tready  = 1'b0;
      stft_tready = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      check("stft_valid_before_reset", stft_tvalid, 1'b1);
      areset = 1'b1;
      @(posedge aclk);
      #1;
      check("midreset_valids", {avg_tvalid, stft_tvalid}, 2'b00);
      areset   = 1'b0;
      reset_model();
      rdy_mode = 0;
      for (int f = 0; f < 2; f++) send_frame(4, 1, 16, 2, 1'b1, 1'b1, 16, 0, 0);
      drain("after_midreset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
